// File: rtl/sd_otf_converter.sv
// On-the-fly conversion of an MSD-first signed-digit stream {-1,0,+1} into a
// two's-complement fraction of DIGITS fraction bits plus sign, via valid/ready.
module sd_otf_converter #(
  parameter int unsigned DIGITS = 20
) (
  input  logic              clk,
  input  logic              asyn_reset,
  input  logic [1:0]        digit_in,
  input  logic              data_in_vld,
  output logic              data_in_rdy,
  output logic [DIGITS:0]   data_out,
  output logic              data_out_vld,
  input  logic              data_out_rdy,
  output logic              digit_err
);

  localparam int unsigned W  = DIGITS + 1;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [0:0]    state;
  logic [W-1:0]  q, qm;
  logic [W-1:0]  q_nxt, qm_nxt;
  logic [CW-1:0] cnt;

  assign data_in_rdy  = (state == ACCUM);
  assign data_out_vld = (state == DONE);

  // Q holds the converted prefix, QM holds Q minus one ulp; a -1 digit borrows
  // from QM so no carry chain is ever needed. Illegal 10 falls into the 0 arm.
  always_comb begin
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    case (digit_in)
      2'b01: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
      2'b11: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      default: begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
      end
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state     <= ACCUM;
      q         <= '0;
      qm        <= '1;
      cnt       <= '0;
      data_out  <= '0;
      digit_err <= 1'b0;
    end else if (state == ACCUM) begin
      if (data_in_vld) begin
        if (digit_in == 2'b10) begin
          digit_err <= 1'b1;
        end
        if (cnt == LAST) begin
          data_out <= q_nxt;
          state    <= DONE;
          q        <= '0;
          qm       <= '1;
          cnt      <= '0;
        end else begin
          q   <= q_nxt;
          qm  <= qm_nxt;
          cnt <= cnt + 1'b1;
        end
      end
    end else begin
      if (data_out_rdy) begin
        state     <= ACCUM;
        digit_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
// Scoreboard bench for sd_otf_converter at DIGITS=4 with directed digit words.
module tb_sd_otf_converter;

  localparam int unsigned DIGITS = 4;

  logic              clk = 1'b0;
  logic              asyn_reset;
  logic [1:0]        digit_in;
  logic              data_in_vld;
  logic              data_in_rdy;
  logic [DIGITS:0]   data_out;
  logic              data_out_vld;
  logic              data_out_rdy;
  logic              digit_err;

  int checks = 0;
  int errors = 0;
  logic [DIGITS+1:0] sb[$];

  sd_otf_converter #(.DIGITS(DIGITS)) dut (
    .clk          (clk),
    .asyn_reset   (asyn_reset),
    .digit_in     (digit_in),
    .data_in_vld  (data_in_vld),
    .data_in_rdy  (data_in_rdy),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy),
    .digit_err    (digit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation on every output transfer.
  always @(negedge clk) begin
    if (!asyn_reset && data_out_vld && data_out_rdy) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        logic [DIGITS+1:0] e;
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e[DIGITS:0]));
        chk("digit_err", 32'(digit_err), 32'(e[DIGITS+1]));
      end
    end
  end

  localparam logic [1:0] P = 2'b01, Z = 2'b00, M = 2'b11, X = 2'b10;

  task automatic send_digit(input logic [1:0] d);
    bit acc;
    int n;
    n = 0;
    digit_in    = d;
    data_in_vld = 1'b1;
    do begin
      @(negedge clk);
      acc = data_in_rdy;
      @(posedge clk);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("input_timeout", 32'd0, 32'd1);
    #1;
    data_in_vld = 1'b0;
    digit_in    = 2'($urandom_range(0, 3));
  endtask

  // Word given MSD first in w[7:6]; expectation pushed when stimulus is issued.
  task automatic send_word(input logic [7:0] w, input logic [DIGITS:0] exp,
                           input logic err, input bit bubbles);
    sb.push_back({err, exp});
    for (int i = 0; i < 4; i++) begin
      if (bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send_digit(w[7-2*i -: 2]);
    end
  endtask

  initial begin
    asyn_reset   = 1'b1;
    digit_in     = 2'b00;
    data_in_vld  = 1'b0;
    data_out_rdy = 1'b1;
    #1;
    chk("rst_vld", 32'(data_out_vld), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_err", 32'(digit_err), 32'd0);
    repeat (2) @(negedge clk);
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rdy", 32'(data_in_rdy), 32'd1);

    // Back-to-back word; latency and single bubble cycle.
    send_word({P, Z, M, P}, 5'b00111, 1'b0, 1'b0);
    chk("lat_vld", 32'(data_out_vld), 32'd1);
    chk("lat_rdy_low", 32'(data_in_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("bubble_rdy_high", 32'(data_in_rdy), 32'd1);
    chk("bubble_vld_low", 32'(data_out_vld), 32'd0);

    // Consecutive words re-initialise Q/QM.
    send_word({M, M, M, M}, 5'b10001, 1'b0, 1'b0);
    send_word({Z, Z, Z, Z}, 5'b00000, 1'b0, 1'b0);
    send_word({P, M, M, M}, 5'b00001, 1'b0, 1'b0);
    send_word({M, P, P, P}, 5'b11111, 1'b0, 1'b0);

    // Illegal digit converts as 0 and flags the word; next word is clean.
    send_word({P, X, Z, M}, 5'b00111, 1'b1, 1'b0);
    send_word({Z, Z, Z, P}, 5'b00001, 1'b0, 1'b0);

    // Backpressure with extra digits offered while DONE.
    @(posedge clk);
    #1;
    data_out_rdy = 1'b0;
    send_word({P, P, Z, M}, 5'b01011, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", 32'(data_out_vld), 32'd1);
      chk("bp_data", 32'(data_out), 32'b01011);
      chk("bp_rdy", 32'(data_in_rdy), 32'd0);
      digit_in    = P;
      data_in_vld = 1'b1;
      @(posedge clk);
      #1;
    end
    data_in_vld  = 1'b0;
    data_out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_vld", 32'(data_out_vld), 32'd0);
    chk("bp_release_rdy", 32'(data_in_rdy), 32'd1);
    send_word({M, Z, P, Z}, 5'b11010, 1'b0, 1'b0);

    // Random input gaps.
    send_word({P, P, P, P}, 5'b01111, 1'b0, 1'b1);

    // Asynchronous reset mid-word discards the partial word and its error.
    @(posedge clk);
    #1;
    send_digit(P);
    send_digit(X);
    chk("pre_rst_err", 32'(digit_err), 32'd1);
    #2;
    asyn_reset = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(data_out_vld), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_err", 32'(digit_err), 32'd0);
    @(negedge clk);
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", 32'(data_in_rdy), 32'd1);
    send_word({Z, P, Z, Z}, 5'b00100, 1'b0, 1'b0);

    begin
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      @(posedge clk);
      chk("sb_drain", 32'(sb.size()), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
